// File: rtl/conv_encoder_mac_if.sv
// Handshake/bus bundle between the conv encoder MAC stage, its pixel source,
// the weight memory and the result sink. The slave modport is the MAC itself.
interface conv_encoder_mac_if #(
    parameter int DATA_W = 18
);
    logic                     x_valid;
    logic signed [DATA_W-1:0] x_data;
    logic                     x_ready;
    logic                     w_start;
    logic [3:0]               w_input_filter;
    logic [3:0]               w_output_filter;
    logic signed [DATA_W-1:0] w;
    logic                     y_valid;
    logic                     y_ready;
    logic signed [DATA_W-1:0] y_data;
    logic [3:0]               y_filter;
    logic                     done;

    modport master (
        output x_valid, x_data, w, y_ready,
        input  x_ready, w_start, w_input_filter, w_output_filter,
               y_valid, y_data, y_filter, done
    );

    modport slave (
        input  x_valid, x_data, w, y_ready,
        output x_ready, w_start, w_input_filter, w_output_filter,
               y_valid, y_data, y_filter, done
    );
endinterface

// File: rtl/conv_encoder_mac.sv
// 1x1 conv encoder MAC: buffers one 14-channel pixel, walks the weight memory and
// emits one saturated fixed-point result per output filter. Define CONV_ENC_RELU_EN to fuse a ReLU.
module conv_encoder_mac #(
    parameter int DATA_W    = 18,
    parameter int FRAC_BITS = 10,
    parameter int N_IN      = 14,
    parameter int N_OUT     = 16
) (
    input  logic clk,
    input  logic rst,
    conv_encoder_mac_if.slave bus
);
    localparam int ACC_W = 2*DATA_W + 4;
    localparam logic [3:0] LAST_IN  = 4'(N_IN - 1);
    localparam logic [3:0] LAST_OUT = 4'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2**(DATA_W-1)) - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    state_t                   state;
    logic [3:0]               cnt;
    logic [3:0]               in_idx;
    logic [3:0]               out_idx;
    logic signed [DATA_W-1:0] pix [N_IN];
    logic                     p_valid;
    logic signed [DATA_W-1:0] p_x;
    logic signed [ACC_W-1:0]  acc;
    logic                     w_start;
    logic                     y_valid;
    logic signed [DATA_W-1:0] y_data;
    logic [3:0]               y_filter;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [DATA_W-1:0]   y_sat;

    // p_x is registered alongside w_start so it lines up with the memory's one-cycle read latency
    always_comb begin
        prod     = p_x * bus.w;
        prod_ext = '0;
        if (p_valid)
            prod_ext = ACC_W'(prod);
        acc_next = acc + prod_ext;
        shifted  = acc_next >>> FRAC_BITS;
        if (shifted > Y_MAX)
            y_sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (shifted < ~Y_MAX)
            y_sat = {1'b1, {(DATA_W-1){1'b0}}};
        else
            y_sat = shifted[DATA_W-1:0];
`ifdef CONV_ENC_RELU_EN
        if (y_sat[DATA_W-1])
            y_sat = '0;
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            in_idx   <= '0;
            out_idx  <= '0;
            p_valid  <= 1'b0;
            p_x      <= '0;
            acc      <= '0;
            w_start  <= 1'b0;
            y_valid  <= 1'b0;
            y_data   <= '0;
            y_filter <= '0;
        end else begin
            p_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.x_valid) begin
                        pix[cnt] <= bus.x_data;
                        if (cnt == LAST_IN) begin
                            cnt     <= '0;
                            in_idx  <= '0;
                            out_idx <= '0;
                            acc     <= '0;
                            w_start <= 1'b1;
                            state   <= ISSUE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ISSUE: begin
                    p_valid <= 1'b1;
                    p_x     <= pix[in_idx];
                    acc     <= acc_next;
                    if (in_idx == LAST_IN) begin
                        w_start <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        in_idx <= in_idx + 4'd1;
                    end
                end
                DRAIN: begin
                    acc      <= acc_next;
                    y_valid  <= 1'b1;
                    y_data   <= y_sat;
                    y_filter <= out_idx;
                    state    <= OUT;
                end
                OUT: begin
                    if (bus.y_ready) begin
                        y_valid <= 1'b0;
                        if (out_idx == LAST_OUT) begin
                            state <= IDLE;
                        end else begin
                            out_idx <= out_idx + 4'd1;
                            in_idx  <= '0;
                            acc     <= '0;
                            w_start <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.x_ready         = (state == IDLE);
    assign bus.w_start         = w_start;
    assign bus.w_input_filter  = in_idx;
    assign bus.w_output_filter = out_idx;
    assign bus.y_valid         = y_valid;
    assign bus.y_data          = y_data;
    assign bus.y_filter        = y_filter;
    // done coincides with the filter-15 handshake itself, so it cannot be a registered flag
    assign bus.done            = y_valid && bus.y_ready && (y_filter == LAST_OUT);
endmodule
